// File: rtl/seven_seg_scan_ctrl_if.sv
// seven_seg_scan_ctrl_if: display-data and panel-drive signals of the seven-segment scan controller
// master drives value/dp_in/digit_en/load and observes the panel; slave is the controller.
interface seven_seg_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  modport master (output value, dp_in, digit_en, load, input an, seg, dp, frame_done);
  modport slave  (input value, dp_in, digit_en, load, output an, seg, dp, frame_done);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: 4-digit multiplexed seven-segment scanner with blanking gaps and frame-synchronous updates
// Ports: clk; reset_n (async, active-low); bus (slave modport): value/dp_in/digit_en/load in,
//   an/seg/dp (active-low, registered) and frame_done (one-cycle pulse) out.
// Option: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3..1.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  seven_seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic {BLANK, DRIVE} state_t;
  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  dpr;
    logic [3:0]  en;
  } disp_t;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  disp_t         pend_q, pend_d, disp_q, disp_d;
  logic [3:0]    an_q, an_d, lz_blank, nib;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d, frame_done_q, frame_done_d, slot_end, show;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic hz;
  // hz: every digit above i is zero or disabled
  always_comb begin
    hz = 1'b1;
    lz_blank = 4'b0000;
    for (int i = 3; i >= 1; i--) begin
      lz_blank[i] = hz && disp_q.val[4*i +: 4] == 4'h0;
      hz = hz && (lz_blank[i] || !disp_q.en[i]);
    end
  end
`else
  assign lz_blank = 4'b0000;
`endif
  // Outputs are decoded from the next state so the registered pins line up with state_q.
  // disp_q is safe here: it only changes on the edge into BLANK, when nothing is driven.
  always_comb begin
    slot_end = state_q == BLANK ? cnt_q == CW'(BLANK_CYCLES - 1) : cnt_q == CW'(REFRESH_DIV - 1);
    state_d = slot_end ? (state_q == BLANK ? DRIVE : BLANK) : state_q;
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = slot_end && state_q == DRIVE ? idx_q + 2'd1 : idx_q;
    frame_done_d = slot_end && state_q == DRIVE && idx_q == 2'd3;
    disp_d = frame_done_d ? pend_q : disp_q;
    pend_d = bus.load ? disp_t'({bus.value, bus.dp_in, bus.digit_en}) : pend_q;
    nib = disp_q.val[{idx_d, 2'b00} +: 4];
    show = state_d == DRIVE && disp_q.en[idx_d];
    an_d = show ? ~(4'b0001 << idx_d) : 4'b1111;
    seg_d = show && !lz_blank[idx_d] ? SEG_LUT[nib] : 7'b1111111;
    dp_d = !(show && disp_q.dpr[idx_d]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: self-checking bench comparing the scanner against a cycle/frame arithmetic model
module tb_seven_seg_scan_ctrl;
  localparam int R = 4, B = 2, SLOT = R + B, P = 4 * SLOT;
  localparam logic [12:0] BLANK_OUT = {4'hf, 7'h7f, 1'b1, 1'b0};
  localparam logic [6:0] LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  int n_cmp = 0, n_fail = 0, t = 0;
  logic [23:0] m_pend = '0, m_disp = '0;
  logic [12:0] obs;
  seven_seg_scan_ctrl_if bus ();
  seven_seg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  assign obs = {bus.an, bus.seg, bus.dp, bus.frame_done};
  always #5 clk = ~clk;
  // Model: t counts cycles since reset release; frames are P cycles; a frame shows what was pending at its start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t <= 0;
      m_pend <= '0;
      m_disp <= '0;
    end else begin
      if ((t + 1) % P == 0) m_disp <= m_pend;
      if (bus.load) m_pend <= {bus.value, bus.dp_in, bus.digit_en};
      t <= t + 1;
    end
  end
  function automatic logic [12:0] expect_out();
    int pos = t % P;
    int d = pos / SLOT;
    logic [15:0] v = m_disp[23:8];
    logic [3:0] nib = v[4*d +: 4];
    logic on = (pos % SLOT >= B) && m_disp[d];
    logic [6:0] s = LUT[nib];
    logic lead = LZ && d > 0 && nib == 4'h0;
    for (int j = d + 1; j < 4; j++) if (v[4*j +: 4] != 4'h0 && m_disp[j]) lead = 1'b0;
    if (lead) s = 7'h7f;
    return {on ? ~(4'b0001 << d) : 4'hf, on ? s : 7'h7f, !(on && m_disp[4 + d]), t >= P && pos == 0};
  endfunction
  task automatic set_load(input logic [15:0] v, input logic [3:0] dpr, input logic [3:0] en);
    bus.value = v;
    bus.dp_in = dpr;
    bus.digit_en = en;
    bus.load = 1'b1;
  endtask
  task automatic do_reset(input logic [15:0] v, input logic [3:0] dpr, input logic [3:0] en);
    @(negedge clk);
    bus.load = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    set_load(v, dpr, en);
    reset_n = 1'b1;
  endtask
  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== BLANK_OUT) begin n_fail++; $display("FAIL reset_hold obs=%h exp=%h", obs, BLANK_OUT); end
    end
  endtask
  task automatic test_scan;
    logic [12:0] e;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_tab [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    do_reset(16'h12AF, 4'h0, 4'hF);
    repeat (3 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL scan t=%0d obs=%h exp=%h", t, obs, e); end
      if (t / P == 1 && t % SLOT == 2) begin
        n_cmp++;
        if ({bus.an, bus.seg} !== {an_tab[t % P / SLOT], seg_tab[t % P / SLOT]}) begin
          n_fail++; $display("FAIL scan_digit t=%0d an/seg=%b/%b exp=%b/%b", t, bus.an, bus.seg, an_tab[t % P / SLOT], seg_tab[t % P / SLOT]);
        end
      end
      if (t < P && t % SLOT == 3) begin
        n_cmp++;
        if (bus.an !== 4'hF) begin n_fail++; $display("FAIL first_frame_blank t=%0d an=%b exp=1111", t, bus.an); end
      end
    end
  endtask
  task automatic test_last_wins;
    logic [12:0] e;
    int f0 = t / P;
    repeat (3 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL last_wins t=%0d obs=%h exp=%h", t, obs, e); end
      if (t / P == f0 + 2 && t % SLOT == 3) begin
        n_cmp++;
        if (bus.seg !== 7'b0100100) begin n_fail++; $display("FAIL last_wins_seg t=%0d seg=%b exp=0100100", t, bus.seg); end
      end
      if (t / P == f0 + 1 && t % P == 5) set_load(16'h0000, 4'h0, 4'hF);
      if (t / P == f0 + 1 && t % P == 8) set_load(16'h5555, 4'h0, 4'hF);
    end
  endtask
  task automatic test_wrap_load;
    logic [12:0] e;
    int f0 = t / P;
    repeat (4 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL wrap_load t=%0d obs=%h exp=%h", t, obs, e); end
      if (t / P == f0 + 2 && t % SLOT == 3) begin
        n_cmp++;
        if (bus.seg !== 7'b0100100) begin n_fail++; $display("FAIL wrap_old_value t=%0d seg=%b exp=0100100", t, bus.seg); end
      end
      if (t / P == f0 + 3 && t % P == 3) begin
        n_cmp++;
        if (bus.seg !== 7'b1000010) begin n_fail++; $display("FAIL wrap_new_value t=%0d seg=%b exp=1000010", t, bus.seg); end
      end
      if (t % P == 0) begin
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done t=%0d got=%b exp=1", t, bus.frame_done); end
      end
      if (t / P == f0 + 1 && t % P == P - 1) set_load(16'h9A3D, 4'h0, 4'hF);
    end
  endtask
  task automatic test_enables;
    logic [12:0] e;
    int f0 = t / P;
    int d;
    repeat (3 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      d = t % P / SLOT;
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL enables t=%0d obs=%h exp=%h", t, obs, e); end
      if (t / P == f0 + 2 && d[0] && t % SLOT >= B) begin
        n_cmp++;
        if ({bus.an, bus.seg} !== {4'hF, 7'h7f}) begin n_fail++; $display("FAIL disabled_digit t=%0d an/seg=%b/%b exp=1111/1111111", t, bus.an, bus.seg); end
      end
      if (t / P == f0 + 2 && t % P == 3) begin
        n_cmp++;
        if ({bus.an, bus.seg, bus.dp} !== {4'b1110, 7'b1001111, 1'b0}) begin n_fail++; $display("FAIL dp_digit0 t=%0d an/seg/dp=%b/%b/%b exp=1110/1001111/0", t, bus.an, bus.seg, bus.dp); end
      end
      if (t / P == f0 + 1 && t % P == 5) set_load(16'h8421, 4'b0001, 4'b0101);
    end
  endtask
  task automatic test_leading_zero;
    logic [12:0] e;
    int f0 = t / P;
    int d;
    logic [6:0] es;
    repeat (3 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      d = t % P / SLOT;
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL leading_zero t=%0d obs=%h exp=%h", t, obs, e); end
      if (t / P == f0 + 2 && t % SLOT == 3) begin
        es = d == 1 ? 7'b0001111 : (d == 0 || !LZ) ? 7'b0000001 : 7'h7f;
        n_cmp++;
        if (bus.seg !== es) begin n_fail++; $display("FAIL leading_zero_seg digit=%0d seg=%b exp=%b", d, bus.seg, es); end
      end
      if (t / P == f0 + 1 && t % P == 5) set_load(16'h0070, 4'h0, 4'hF);
    end
  endtask
  task automatic test_async_reset;
    logic [12:0] e;
    int guard = 0;
    do begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL async_pre t=%0d obs=%h exp=%h", t, obs, e); end
      guard++;
    end while (t % P != 2 * SLOT + B + 2 && guard < 2 * P);
    n_cmp++;
    if (bus.an !== 4'b1011) begin n_fail++; $display("FAIL async_precondition an=%b exp=1011", bus.an); end
    #1 reset_n = 1'b0;
    #1 n_cmp++;
    if (obs !== BLANK_OUT) begin n_fail++; $display("FAIL async_immediate obs=%h exp=%h", obs, BLANK_OUT); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 n_cmp++;
    if (obs !== BLANK_OUT) begin n_fail++; $display("FAIL async_release obs=%h exp=%h", obs, BLANK_OUT); end
    repeat (2 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL async_restart t=%0d obs=%h exp=%h", t, obs, e); end
      if (t == P + 1 || t == P + 2) begin
        n_cmp++;
        if (bus.an !== (t == P + 1 ? 4'b1111 : 4'b1110)) begin n_fail++; $display("FAIL async_digit0 t=%0d an=%b", t, bus.an); end
      end
      if (t == 5) set_load(16'h12AF, 4'h0, 4'hF);
    end
  endtask
  task automatic test_random;
    logic [12:0] e;
    repeat (8 * P) begin
      @(negedge clk);
      bus.load = 1'b0;
      e = expect_out();
      n_cmp++;
      if (obs !== e) begin n_fail++; $display("FAIL random t=%0d obs=%h exp=%h", t, obs, e); end
      if ($urandom_range(0, 5) == 0) set_load(16'($urandom) >> $urandom_range(0, 15), 4'($urandom), 4'($urandom));
    end
  endtask
  initial begin
    bus.value = '0;
    bus.dp_in = '0;
    bus.digit_en = '0;
    bus.load = 1'b0;
    test_reset();
    test_scan();
    test_last_wins();
    test_wrap_load();
    test_enables();
    test_leading_zero();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles each digit is driven (legal >= 2).
REQ-002 Parameter BLANK_CYCLES, default 1000, all-anodes-off cycles before each digit (legal >= 1).
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port value  input  16  four hex digits; [3:0] is digit 0, the rightmost.
REQ-006 Port dp_in  input  4  decimal point per digit, active-high request.
REQ-007 Port digit_en  input  4  per-digit enable; 0 blanks that digit.
REQ-008 Port load  input  1  single-cycle strobe capturing value, dp_in and digit_en.
REQ-009 Port an  output  4  anode selects, active-low, registered.
REQ-010 Port seg  output  7  segments {a,b,c,d,e,f,g}, active-low, registered.
REQ-011 Port dp  output  1  decimal-point segment, active-low, registered.
REQ-012 Port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 FSM has two states, BLANK and DRIVE; digit index idx is 2 bits; a cycle counter cnt sizes to the larger parameter.
REQ-014 BLANK lasts exactly BLANK_CYCLES cycles; an=4'b1111, seg=7'b1111111, dp=1.
REQ-015 DRIVE lasts exactly REFRESH_DIV cycles; an[idx]=0, other anodes 1; seg and dp are taken from the display register for idx.
REQ-016 At the end of DRIVE, idx increments modulo 4 (3 wraps to 0), cnt clears and the FSM enters BLANK.
REQ-017 Segment encoding (active-low {a..g}): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-018 A digit with digit_en=0 in the display register keeps its DRIVE slot length, but an stays 4'b1111, seg=7'b1111111 and dp=1.
REQ-019 load writes value, dp_in and digit_en into a pending register in the same cycle.
REQ-020 The pending register copies into the display register only on the BLANK-entry edge where idx wraps 3->0. This boundary prevents a frame from mixing digits of two values.
REQ-021 A load on that same boundary edge goes to pending only and is displayed from the following frame.
REQ-022 Back-to-back loads within a frame: the last one wins.
REQ-023 frame_done=1 for exactly the first BLANK cycle of digit 0 after each wrap, and never in the first frame after reset.
REQ-024 All outputs are registered, with no combinational path from inputs to outputs.
REQ-025 Frame period = 4*(REFRESH_DIV+BLANK_CYCLES) cycles, with no gaps.

Reset
REQ-026 While reset_n=0, all of the following hold asynchronously: an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, state=BLANK, idx=0, cnt=0, pending and display registers = value 0, dp 0, digit_en 4'b0000.
REQ-027 A reset asserted mid-DRIVE blanks the display immediately, with no completion of the slot.
REQ-028 The first BLANK begins on the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN, when defined, blanks digits 3..1 holding 0 while every higher digit is 0 or disabled; digit 0 is always shown if enabled; dp still follows the dp request.
REQ-030 When the macro is undefined, every enabled digit displays its hex value, including leading zeros.

Verification (bench uses REFRESH_DIV=4, BLANK_CYCLES=2)
REQ-031 Release reset with load value=16'h12AF, digit_en=4'hF, dp_in=0. Frame 1 shows all blank; from frame 2: an 1110/seg 0111000, 1101/0001000, 1011/0010010, 0111/1001111, each held 4 cycles after 2 blank cycles; period 24.
REQ-032 Load 16'h0000, then 16'h5555 three cycles later within the same frame. Only 5 (0100100) appears, on every digit, starting at the next frame.
REQ-033 Load on the wrap edge. The old value persists for one more full frame; frame_done pulses at cycles 24, 48, ...
REQ-034 Load digit_en=4'b0101, dp_in=4'b0001. Digits 1 and 3 keep an=1111 for 4 cycles; digit 0 shows dp=0.
REQ-035 Assert reset_n=0 at cycle 2 of digit 2 DRIVE. an=1111 and seg=1111111 within the same cycle, with no clock edge; after release the sequence restarts at digit 0 BLANK.
REQ-036 With SEVEN_SEG_LEADING_ZERO_BLANK_EN defined, load 16'h0070. Digits 3 and 2 are blank; digit 1 shows 7; digit 0 shows 0 (0000001). With the macro undefined, all four digits are shown.
